clcd_ctrl: RTL and testbench



---
 rtl/clcd_pkg.sv | 41 ++++
 rtl/clcd_fifo.sv | 66 ++++++
 rtl/clcd_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_clcd_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clcd_pkg
// Brief    : Shared types and constants for the character-LCD sequencer.
//            Autowrap helpers are used only when CLCD_AUTOWRAP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package clcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_E_HIGH = 3'd3,
        ST_HOLD   = 3'd4,
        ST_WAIT   = 3'd5
    } clcd_state_e;

    localparam int         c_init_len   = 4;
    // Bytes 0x00-0x03 with RS=0 are clear/home and need the long wait
    localparam logic [7:0] c_clr_mask   = 8'hFC;
    localparam logic [7:0] c_line1_base = 8'h80;
    localparam logic [7:0] c_line2_base = 8'hC0;
    localparam logic [4:0] c_line_chars = 5'd16;

    // Function set 8-bit/2-line, display on, clear, entry mode increment
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    function automatic logic is_clr(input logic rs, input logic [7:0] data);
        return !rs && ((data & c_clr_mask) == 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clcd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : clcd_fifo
// Brief    : Synchronous first-word-fall-through FIFO with full/empty/level.
// Revision : 1.0 - initial release
// ============================================================================
module clcd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_level;
    logic             w_push;
    logic             w_pop;

    // Full is taken from the current level, so a same-cycle pop cannot admit a push
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_level == (c_aw + 1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (c_aw + 1)'(1);
                2'b01:   r_level <= r_level - (c_aw + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/clcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clcd_ctrl
// Brief    : HD44780-style character-LCD sequencer: power-up init, then drains
//            a {RS, byte} FIFO with E-pulse and per-command wait timing.
//            Optional macro CLCD_AUTOWRAP_EN adds 16x2 line wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module clcd_ctrl #(
    parameter int FIFO_DEPTH     = 16,
    parameter int PWRUP_WAIT_CYC = 1000000,
    parameter int E_PW_CYC       = 25,
    parameter int SETUP_CYC      = 2,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLR_WAIT_CYC   = 100000
) (
    input  logic                          clk,
    input  logic                          nRESET,
    input  logic                          wr_en,
    input  logic                          wr_rs,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf,
    output logic                          init_done,
    output logic                          busy,
    output logic                          CLCD_RS,
    output logic                          CLCD_RW,
    output logic                          CLCD_E,
    output logic [7:0]                    CLCD_DQ
);

    import clcd_pkg::*;

    localparam int          c_lvl_w      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] c_pwrup_last = 32'(PWRUP_WAIT_CYC - 1);
    localparam logic [31:0] c_epw_last   = 32'(E_PW_CYC - 1);
    localparam logic [31:0] c_setup_last = 32'(SETUP_CYC - 1);
    localparam logic [31:0] c_cmd_last   = 32'(CMD_WAIT_CYC - 1);
    localparam logic [31:0] c_clr_last   = 32'(CLR_WAIT_CYC - 1);
    localparam logic [1:0]  c_init_last  = 2'(c_init_len - 1);

    clcd_state_e        r_state;
    clcd_state_e        w_state_nxt;
    logic [31:0]        r_timer;
    logic [31:0]        w_wait_last;
    logic               r_rs;
    logic [7:0]         r_dq;
    logic               r_e;
    logic [1:0]         r_init_idx;
    logic               r_init_done;
    logic               r_ovf;
    logic               r_busy;

    logic               w_load;
    logic               w_load_rs;
    logic [7:0]         w_load_dq;
    logic               w_pop;
    logic               w_init_adv;
    logic               w_set_done;

    logic [8:0]         w_fifo_q;
    logic               w_full;
    logic               w_empty;
    logic [c_lvl_w-1:0] w_level;

`ifdef CLCD_AUTOWRAP_EN
    logic [4:0]         r_col;
    logic               r_line;
`endif

    clcd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (nRESET),
        .i_push  (wr_en),
        .i_data  ({wr_rs, wr_data}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign w_wait_last = is_clr(r_rs, r_dq) ? c_clr_last : c_cmd_last;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= ST_PWRUP;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_rs   = 1'b0;
        w_load_dq   = 8'h00;
        w_pop       = 1'b0;
        w_init_adv  = 1'b0;
        w_set_done  = 1'b0;
        case (r_state)
            ST_PWRUP: begin
                if (r_timer == c_pwrup_last) begin
                    w_load      = 1'b1;
                    w_load_dq   = init_cmd(2'd0);
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_IDLE: begin
                if (!w_empty) begin
`ifdef CLCD_AUTOWRAP_EN
                    // A full line gets a cursor move before the next queued entry
                    if (r_col == c_line_chars) begin
                        w_load    = 1'b1;
                        w_load_dq = r_line ? c_line1_base : c_line2_base;
                    end else begin
                        w_pop     = 1'b1;
                        w_load    = 1'b1;
                        w_load_rs = w_fifo_q[8];
                        w_load_dq = w_fifo_q[7:0];
                    end
`else
                    w_pop     = 1'b1;
                    w_load    = 1'b1;
                    w_load_rs = w_fifo_q[8];
                    w_load_dq = w_fifo_q[7:0];
`endif
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_timer == c_setup_last) begin
                    w_state_nxt = ST_E_HIGH;
                end
            end
            ST_E_HIGH: begin
                if (r_timer == c_epw_last) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_timer == c_setup_last) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_timer == w_wait_last) begin
                    if (r_init_done) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_init_idx == c_init_last) begin
                        w_set_done  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_init_adv  = 1'b1;
                        w_load      = 1'b1;
                        w_load_dq   = init_cmd(r_init_idx + 2'd1);
                        w_state_nxt = ST_SETUP;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_PWRUP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_rs        <= 1'b0;
            r_dq        <= 8'h00;
            r_e         <= 1'b0;
            r_init_idx  <= 2'd0;
            r_init_done <= 1'b0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_e <= (w_state_nxt == ST_E_HIGH);
            if (w_load) begin
                r_rs <= w_load_rs;
                r_dq <= w_load_dq;
            end
            if (w_init_adv) begin
                r_init_idx <= r_init_idx + 2'd1;
            end
            if (w_set_done) begin
                r_init_done <= 1'b1;
            end
            if (wr_en && w_full) begin
                r_ovf <= 1'b1;
            end
            r_busy <= (r_state != ST_IDLE) || !w_empty;
        end
    end

`ifdef CLCD_AUTOWRAP_EN
    // Tracks what the display cursor will be after each byte the sequencer sends
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_col  <= 5'd0;
            r_line <= 1'b0;
        end else if (w_load) begin
            if (is_clr(w_load_rs, w_load_dq)) begin
                r_col  <= 5'd0;
                r_line <= 1'b0;
            end else if (w_load_rs) begin
                r_col <= r_col + 5'd1;
            end else if (w_load_dq[7]) begin
                r_line <= w_load_dq[6];
                r_col  <= {1'b0, w_load_dq[3:0]};
            end
        end
    end
`endif

    assign full      = w_full;
    assign level     = w_level;
    assign ovf       = r_ovf;
    assign init_done = r_init_done;
    assign busy      = r_busy;
    assign CLCD_RS   = r_rs;
    assign CLCD_RW   = 1'b0;
    assign CLCD_E    = r_e;
    assign CLCD_DQ   = r_dq;

endmodule
`default_nettype wire

// File: tb/tb_clcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clcd_ctrl
// Brief    : Directed self-checking bench for clcd_ctrl with shortened timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clcd_ctrl;

    localparam int c_epw = 4;

    logic       clk;
    logic       nRESET;
    logic       wr_en;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       full;
    logic [4:0] level;
    logic       ovf;
    logic       init_done;
    logic       busy;
    logic       CLCD_RS;
    logic       CLCD_RW;
    logic       CLCD_E;
    logic [7:0] CLCD_DQ;

    int cyc;
    int n_tests;
    int n_fail;

    clcd_ctrl #(
        .FIFO_DEPTH     (16),
        .PWRUP_WAIT_CYC (100),
        .E_PW_CYC       (4),
        .SETUP_CYC      (2),
        .CMD_WAIT_CYC   (20),
        .CLR_WAIT_CYC   (200)
    ) dut (
        .clk       (clk),
        .nRESET    (nRESET),
        .wr_en     (wr_en),
        .wr_rs     (wr_rs),
        .wr_data   (wr_data),
        .full      (full),
        .level     (level),
        .ovf       (ovf),
        .init_done (init_done),
        .busy      (busy),
        .CLCD_RS   (CLCD_RS),
        .CLCD_RW   (CLCD_RW),
        .CLCD_E    (CLCD_E),
        .CLCD_DQ   (CLCD_DQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index since reset release: cycle 0 is the period before the first edge
    always @(posedge clk or negedge nRESET) begin
        if (!nRESET) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, act, act, exp, exp);
        end
    endtask

    task automatic wait_e(input logic lvl, output int at);
        int n;
        n  = 0;
        at = -1;
        do begin
            @(negedge clk);
            n++;
        end while (CLCD_E !== lvl && n < 5000);
        if (CLCD_E === lvl) at = cyc;
        else chk("e_wait_timeout", 32'(CLCD_E), 32'(lvl));
    endtask

    task automatic wait_pulse(output int rise, output int fall, output logic rs, output logic [7:0] dq);
        wait_e(1'b1, rise);
        rs = CLCD_RS;
        dq = CLCD_DQ;
        wait_e(1'b0, fall);
    endtask

    task automatic wait_busy_low(output int at);
        int n;
        n  = 0;
        at = -1;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 5000);
        if (busy === 1'b0) at = cyc;
        else chk("busy_wait_timeout", 32'(busy), 32'(0));
    endtask

    task automatic push(input logic rs, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_rs   = rs;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        logic [7:0] init_dq [4];
        int         init_rise [4];
        int         rise, fall, rise2, fall2, at, p, n;
        logic       rs;
        logic [7:0] dq;
        logic       e_rs;
        logic [7:0] e_dq;

        init_dq   = '{8'h38, 8'h0C, 8'h01, 8'h06};
        init_rise = '{102, 130, 158, 366};
        n_tests = 0;
        n_fail  = 0;
        wr_en   = 1'b0;
        wr_rs   = 1'b0;
        wr_data = 8'h00;
        nRESET  = 1'b1;
        #2 nRESET = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_e",     32'(CLCD_E),    32'(0));
        chk("rst_rs",    32'(CLCD_RS),   32'(0));
        chk("rst_rw",    32'(CLCD_RW),   32'(0));
        chk("rst_dq",    32'(CLCD_DQ),   32'(0));
        chk("rst_level", 32'(level),     32'(0));
        chk("rst_full",  32'(full),      32'(0));
        chk("rst_ovf",   32'(ovf),       32'(0));
        chk("rst_done",  32'(init_done), 32'(0));
        chk("rst_busy",  32'(busy),      32'(1));

        // Release, fill the FIFO during power-up, then overflow it
        nRESET = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            push(~i[0], i[0] ? 8'(8'h10 + i) : 8'(8'h60 + i));
        end
        chk("fill_level", 32'(level), 32'(16));
        chk("fill_full",  32'(full),  32'(1));
        chk("fill_ovf",   32'(ovf),   32'(0));
        push(1'b1, 8'hEE);
        chk("ovf_level", 32'(level), 32'(16));
        chk("ovf_set",   32'(ovf),   32'(1));

        // Power-up init sequence
        for (int i = 0; i < 4; i++) begin
            wait_pulse(rise, fall, rs, dq);
            chk("init_rise",  32'(rise),        32'(init_rise[i]));
            chk("init_width", 32'(fall - rise), 32'(c_epw));
            chk("init_rs",    32'(rs),          32'(0));
            chk("init_dq",    32'(dq),          32'(init_dq[i]));
            chk("init_rw",    32'(CLCD_RW),     32'(0));
        end
        chk("done_low_after_pulse", 32'(init_done), 32'(0));
        n = 0;
        while (init_done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("init_done_cyc", 32'(cyc), 32'(392));
        chk("level_held_in_init", 32'(level), 32'(16));

        // Drain the 16 queued entries in order
        for (int i = 0; i < 16; i++) begin
            wait_pulse(rise, fall, rs, dq);
            e_rs = ~i[0];
            e_dq = i[0] ? 8'(8'h10 + i) : 8'(8'h60 + i);
            chk("drain_rs", 32'(rs), 32'(e_rs));
            chk("drain_dq", 32'(dq), 32'(e_dq));
            if (i == 0) chk("drain_first_rise", 32'(rise), 32'(395));
            if (i == 1) chk("drain_entry_cost", 32'(rise - rise2), 32'(29));
            rise2 = rise;
        end
        wait_busy_low(at);
        chk("drain_level", 32'(level), 32'(0));
        chk("drain_full",  32'(full),  32'(0));
        chk("ovf_sticky",  32'(ovf),   32'(1));

        // Single data write: setup, pulse and busy timing
        p = cyc;
        push(1'b1, 8'h41);
        @(negedge clk);
        chk("data_setup_rs", 32'(CLCD_RS), 32'(1));
        chk("data_setup_dq", 32'(CLCD_DQ), 32'(8'h41));
        chk("data_setup_e",  32'(CLCD_E),  32'(0));
        wait_pulse(rise, fall, rs, dq);
        chk("data_rise",  32'(rise),        32'(p + 4));
        chk("data_width", 32'(fall - rise), 32'(c_epw));
        chk("data_rs",    32'(rs),          32'(1));
        chk("data_dq",    32'(dq),          32'(8'h41));
        wait_busy_low(at);
        chk("data_busy_fall", 32'(at - fall), 32'(23));

        // Home command uses the long wait, data the short one
        push(1'b0, 8'h02);
        push(1'b1, 8'h30);
        wait_pulse(rise, fall, rs, dq);
        chk("home_dq", 32'(dq), 32'(8'h02));
        chk("home_rs", 32'(rs), 32'(0));
        wait_pulse(rise2, fall2, rs, dq);
        chk("home_gap", 32'(rise2 - fall), 32'(205));
        chk("d30_dq",   32'(dq), 32'(8'h30));
        chk("d30_rs",   32'(rs), 32'(1));
        wait_busy_low(at);
        chk("d30_busy_fall", 32'(at - fall2), 32'(23));

        // Reset asserted while E is high
        push(1'b1, 8'h55);
        push(1'b1, 8'h56);
        wait_e(1'b1, rise);
        chk("pre_rst_level", 32'(level), 32'(1));
        #2 nRESET = 1'b0;
        #1;
        chk("midrst_e",     32'(CLCD_E),    32'(0));
        chk("midrst_rs",    32'(CLCD_RS),   32'(0));
        chk("midrst_dq",    32'(CLCD_DQ),   32'(0));
        chk("midrst_level", 32'(level),     32'(0));
        chk("midrst_ovf",   32'(ovf),       32'(0));
        chk("midrst_done",  32'(init_done), 32'(0));
        chk("midrst_busy",  32'(busy),      32'(1));
        @(negedge clk);
        nRESET = 1'b1;
        wait_pulse(rise, fall, rs, dq);
        chk("restart_rise",  32'(rise),  32'(102));
        chk("restart_dq",    32'(dq),    32'(8'h38));
        chk("restart_level", 32'(level), 32'(0));

`ifdef CLCD_AUTOWRAP_EN
        for (int i = 0; i < 3; i++) wait_pulse(rise, fall, rs, dq);
        wait_busy_low(at);
        for (int i = 0; i < 17; i++) push(1'b1, 8'(8'h41 + i));
        for (int i = 0; i < 18; i++) begin
            wait_pulse(rise, fall, rs, dq);
            if (i < 16) begin
                e_rs = 1'b1;
                e_dq = 8'(8'h41 + i);
            end else if (i == 16) begin
                e_rs = 1'b0;
                e_dq = 8'hC0;
            end else begin
                e_rs = 1'b1;
                e_dq = 8'h51;
                chk("wrap_cmd_gap", 32'(rise - fall2), 32'(25));
            end
            chk("wrap_rs", 32'(rs), 32'(e_rs));
            chk("wrap_dq", 32'(dq), 32'(e_dq));
            fall2 = fall;
        end
        wait_busy_low(at);
        chk("wrap_level", 32'(level), 32'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
